// File: rtl/fetch_unit.sv
// fetch_unit: program counter, word-aligned instruction fetch and a DEPTH-entry FIFO feeding decode.
// Optional feature macro CINCO_MISALIGN_CHECK_EN: a misaligned redirect yields one poisoned entry, then fetch halts.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_a,
    input  logic [31:0] imem_rd,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_misaligned,
    output logic [1:0]  dbg_state
);

    localparam int unsigned PW       = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    // ST_POISON: misaligned target loaded, one poisoned entry still to push.
    // ST_HALT: poisoned entry pushed, no further fetch until redirect/reset.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_POISON = 2'd1,
        ST_HALT   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW:0]     count_q, count_d;

    logic [31:0]     word_q   [DEPTH];
    logic [31:0]     pc_mem_q [DEPTH];
`ifdef CINCO_MISALIGN_CHECK_EN
    logic            mis_q    [DEPTH];
`endif

    logic            push;
    logic            pop;
    logic            poison;

    // Handshake: an entry transfers to decode on a rising edge where inst_valid
    // and inst_ready are both 1 and no redirect is present; inst_valid never
    // depends on inst_ready, and the head holds steady until it transfers.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        push     = 1'b0;
        pop      = 1'b0;
        poison   = (state_q == ST_POISON);

        if (redirect_valid) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            state_d  = ST_RUN;
`ifdef CINCO_MISALIGN_CHECK_EN
            pc_d = redirect_pc;
            if (redirect_pc[1:0] != 2'b00) begin
                state_d = ST_POISON;
            end
`else
            pc_d = redirect_pc & ~32'h3;
`endif
        end else begin
            pop  = inst_valid & inst_ready;
            push = (state_q != ST_HALT) & ((count_q != FULL_CNT) | pop);

            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                pc_d     = pc_q + 32'd4;
                if (poison) begin
                    state_d = ST_HALT;
                end
            end

            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; count gating on the outputs hides stale entries.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            word_q[wr_ptr_q]   <= poison ? 32'h0 : imem_rd;
            pc_mem_q[wr_ptr_q] <= pc_q;
`ifdef CINCO_MISALIGN_CHECK_EN
            mis_q[wr_ptr_q]    <= poison;
`endif
        end
    end

    assign imem_a     = pc_q;
    assign inst_valid = (count_q != '0);
    assign inst       = inst_valid ? word_q[rd_ptr_q]   : 32'h0;
    assign inst_pc    = inst_valid ? pc_mem_q[rd_ptr_q] : 32'h0;
    assign dbg_state  = state_q;

`ifdef CINCO_MISALIGN_CHECK_EN
    assign inst_misaligned = inst_valid & mis_q[rd_ptr_q];
`else
    assign inst_misaligned = 1'b0;
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the cinco RISC-V core. Holds the program counter, drives the word-aligned instruction memory address, and captures each returned instruction word with its PC into a small FIFO. Presents instructions to decode over a valid/ready handshake, and flushes and restarts on a branch/jump redirect from execute. Sits directly upstream of the instruction memory's combinational read port and feeds the decode stage.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset.
- `DEPTH`, default `2`: FIFO entries; a power of two, ≥2.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `imem_a`  out  32  instruction memory byte address; always equals `pc` (combinational).
- `imem_rd`  in  32  instruction word returned combinationally for `imem_a`.
- `redirect_valid`  in  1  asserts a control-flow change this cycle.
- `redirect_pc`  in  32  target byte address, sampled when `redirect_valid`=1.
- `inst_valid`  out  1  FIFO head is valid.
- `inst_ready`  in  1  decode accepts the head this cycle.
- `inst`  out  32  instruction word at the FIFO head.
- `inst_pc`  out  32  PC of `inst`.
- `inst_misaligned`  out  1  head entry came from a misaligned redirect target.

## Operation
- State:
  - `pc` (32 b).
  - FIFO of `DEPTH` entries of {misaligned, pc, word}.
  - Read/write pointers of log2(`DEPTH`) bits, plus `count` of log2(`DEPTH`)+1 bits.
  - `halted` flag.
- `pop` = `inst_valid & inst_ready`.
- `push` = `!halted & (count < DEPTH | pop)`. On push:
  - Write {0, `pc`, `imem_rd`}.
  - `pc` <= `pc` + 4, modulo 2^32, so `32'hFFFF_FFFC` wraps to `0`.
- Full with pop in the same cycle: push and pop both occur and `count` is unchanged.
- Empty: no pop. `inst`, `inst_pc` and `inst_misaligned` read 0 while `inst_valid`=0.
- Redirect has priority over everything. When `redirect_valid`=1:
  - Flush: `count` <= 0, pointers <= 0, `halted` <= 0.
  - `pc` <= `redirect_pc`.
  - Suppress push and pop this cycle, even if `inst_ready`=1 and `inst_valid`=1.
- `imem_a` carries the full `pc`. Memory ignores bits [1:0].

## Timing
- Reset (`rst_n`=0 at an edge):
  - `pc` = `RESET_PC`, `count` = 0, `halted` = 0.
  - Outputs: `inst_valid`=0, `inst`=0, `inst_pc`=0, `inst_misaligned`=0, `imem_a`=`RESET_PC`.
  - Reset overrides redirect and any handshake in progress. FIFO contents are discarded.
- First instruction: `inst_valid`=1 in the first cycle after the first edge with `rst_n`=1.
- Fetch-to-decode latency: 1 cycle (word registered into the FIFO).
- Redirect latency:
  - Cycle after redirect: `inst_valid`=0.
  - Following cycle: target instruction valid, with `inst_pc`=`redirect_pc`.
- Throughput: 1 instruction/cycle while `inst_ready` is held high.
- Backpressure: the FIFO fills to `DEPTH`, then `pc` holds. `inst` and `inst_pc` are stable while `inst_valid`=1 and `inst_ready`=0.

## Configuration
- Macro `CINCO_MISALIGN_CHECK_EN`.
- Defined:
  - A redirect with `redirect_pc[1:0]`≠0 sets `halted`=1 in the following cycle, in addition to the normal redirect behaviour.
  - While halted, the next cycle pushes one entry {1, `pc`, 32'h0} regardless of `imem_rd`, then no further pushes occur.
  - `halted` clears only on reset or the next redirect.
  - `inst_misaligned`=1 on that entry.
- Undefined:
  - `redirect_pc[1:0]` is forced to 00 when loaded into `pc`.
  - `halted` never sets.
  - `inst_misaligned` is tied 0.

## Test plan
- Reset release, `RESET_PC`=0, memory words 0..3 = `32'h00500093`, `32'h00100113`, `32'h002081B3`, `32'h00000013`, `inst_ready`=1 → from cycle 1, one word per cycle in order, with `inst_pc` 0, 4, 8, 12.
- `inst_ready`=0 for 5 cycles after the first valid → `inst`/`inst_pc` stable at word 0 / 0. After 2 cycles `count`=2 and `imem_a` holds 8. On release, words 0, 1, 2 come out back-to-back with no gap or duplicate.
- Redirect to `32'h40` while the FIFO holds 2 entries and `inst_ready`=1 → no pop that cycle, next cycle `inst_valid`=0, then `inst_pc`=`32'h40` with `inst`=mem[16].
- FIFO full with `inst_ready`=1 every cycle → simultaneous push/pop and steady 1/cycle throughput. `RESET_PC`=`32'hFFFF_FFF8` → `inst_pc` sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- With `CINCO_MISALIGN_CHECK_EN`, redirect to `32'h42` → one entry with `inst_pc`=`32'h42`, `inst`=0, `inst_misaligned`=1, then `inst_valid`=0 indefinitely until a redirect to `32'h80` resumes normal fetch. Without the macro, the same stimulus gives `inst_pc`=`32'h40`, `inst_misaligned`=0.
- `rst_n`=0 asserted mid-stream together with `redirect_valid`=1 → next cycle `inst_valid`=0, `imem_a`=`RESET_PC`, and the redirect is ignored.
